// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: multiply/divide op encodings and the default
// cycle counts for the multi-cycle MD unit.
package mips_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: latched operands and op in, 64-bit
// {hi,lo} result out, plus a flag for a divide whose divisor is zero.
module md_calc
    import mips_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        is_div;
    logic [31:0] divisor;

    always_comb begin
        is_div   = (op == MD_DIV) || (op == MD_DIVU);
        div_zero = is_div && (b == '0);
        // Substitute 1 for a zero divisor so the datapath never divides by zero;
        // the result is discarded in that case anyway.
        divisor  = (b == '0) ? 32'd1 : b;
        result   = '0;
        case (op)
            MD_MULT:  result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            MD_MULTU: result = {32'd0, a} * {32'd0, b};
            MD_DIV:   result = {32'($signed(a) % $signed(divisor)),
                                32'($signed(a) / $signed(divisor))};
            MD_DIVU:  result = {a % divisor, a / divisor};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multi-cycle multiply/divide unit holding architectural HI/LO;
// busy is a registered status the hazard unit uses to stall later MD ops.
module md_unit
    import mips_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      hi_q, lo_q, hi_next, lo_next;
    logic [31:0]      a_q, b_q;
    md_op_t           op_q, op_in;
    logic             latch;
    logic [63:0]      result;
    logic             div_zero;

    assign op_in = md_op_t'(md_op);

    md_calc u_calc (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .result   (result),
        .div_zero (div_zero)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hi_next    = hi_q;
        lo_next    = lo_q;
        latch      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    case (op_in)
                        MD_MULT, MD_MULTU: begin
                            latch      = 1'b1;
                            cnt_next   = CNT_W'(MULT_CYCLES);
                            state_next = MD_BUSY;
                        end
                        MD_DIV, MD_DIVU: begin
                            latch      = 1'b1;
                            cnt_next   = CNT_W'(DIV_CYCLES);
                            state_next = MD_BUSY;
                        end
                        MD_MTHI: hi_next = src_a;
                        MD_MTLO: lo_next = src_a;
                        default: ;
                    endcase
                end
            end
            MD_BUSY: begin
                // start is deliberately ignored here; the hazard unit stalls it
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = MD_IDLE;
                    if (!div_zero) begin
                        hi_next = result[63:32];
                        lo_next = result[31:0];
                    end
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= MD_NONE;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            hi_q  <= hi_next;
            lo_q  <= lo_next;
            if (latch) begin
                a_q  <= src_a;
                b_q  <= src_b;
                op_q <= op_in;
            end
        end
    end

    assign busy = (state == MD_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: products, quotients, MTHI/MTLO,
// divide by zero, start-while-busy and mid-operation reset.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Holds start for one cycle, then scrambles operands; returns at the
    // falling edge of the first cycle after the start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; src_a = $urandom; src_b = $urandom;
    endtask

    // Counts busy cycles starting at the current cycle, bounded at 60.
    task automatic count_busy(input int already, output int n);
        n = already;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        logic stayed_zero;

        reset = 1'b1; start = 1'b0; md_op = '0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);

        issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
        count_busy(0, n);
        check("mult_busy_cycles", 32'(n), 32'd5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFF1);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        count_busy(0, n);
        check("multu_busy_cycles", 32'(n), 32'd5);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        issue(OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD);
        count_busy(0, n);
        check("mult_negneg_hi", hi, 32'h0);
        check("mult_negneg_lo", lo, 32'd6);

        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        count_busy(0, n);
        check("div_busy_cycles", 32'(n), 32'd10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
        count_busy(0, n);
        check("div_negdivisor_lo", lo, 32'hFFFFFFFD);
        check("div_negdivisor_hi", hi, 32'd1);

        issue(OP_DIVU, 32'd100, 32'd7);
        count_busy(0, n);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        issue(OP_MTHI, 32'h0000AAAA, 32'h0);
        check("mthi_hi", hi, 32'h0000AAAA);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(OP_MTLO, 32'h00005555, 32'h0);
        check("mtlo_lo", lo, 32'h00005555);
        check("mtlo_keeps_hi", hi, 32'h0000AAAA);

        issue(OP_RSVD, 32'h12345678, 32'h9);
        check("rsvd_busy", 32'(busy), 32'd0);
        check("rsvd_hi", hi, 32'h0000AAAA);
        check("rsvd_lo", lo, 32'h00005555);

        issue(OP_DIVU, 32'd7, 32'd0);
        count_busy(0, n);
        check("divzero_busy_cycles", 32'(n), 32'd10);
        check("divzero_hi", hi, 32'h0000AAAA);
        check("divzero_lo", lo, 32'h00005555);

        issue(OP_MTLO, 32'h00001234, 32'h0);
        check("mtlo2_lo", lo, 32'h00001234);
        check("mtlo2_busy", 32'(busy), 32'd0);

        // MTHI presented during busy cycle 2 of a MULT must be ignored
        issue(OP_MULT, 32'h00001000, 32'h00000300);
        @(negedge clk);
        start = 1'b1; md_op = OP_MTHI; src_a = 32'h0000BEEF;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        count_busy(2, n);
        check("mthi_in_busy_cycles", 32'(n), 32'd5);
        check("mthi_in_busy_hi", hi, 32'h0);
        check("mthi_in_busy_lo", lo, 32'h00300000);

        // Reset during busy cycle 3 of DIV 100/7 discards the result
        issue(OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_hi", hi, 32'h0);
        check("midreset_lo", lo, 32'h0);
        stayed_zero = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) stayed_zero = 1'b0;
        end
        check("midreset_no_late_write", 32'(stayed_zero), 32'd1);

        issue(OP_MULTU, 32'd3, 32'd4);
        count_busy(0, n);
        check("post_reset_multu_cycles", 32'(n), 32'd5);
        check("post_reset_multu_lo", lo, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
